seq_shift_add_mul: RTL and testbench

Iterative radix-2 shift-add multiplier, parametrised in operand width and fixed-point format, with signed or unsigned operation selected per transaction.
Produces one partial-product step per clock.
Valid/ready handshakes on input and output, for use by attention-score and softmax datapaths that cannot afford a parallel multiplier.
Outputs both the full-width product and a truncated, saturated fixed-point result.

---
 rtl/mul_pkg.sv | 28 ++
 rtl/mul_fix_sat.sv | 39 +++
 rtl/seq_shift_add_mul.sv | 126 ++++++++++++
 tb/tb_seq_shift_add_mul.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier and its fixed-point post-processing.
// Holds the controller state encoding and the saturation-limit helpers.
package mul_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StCalc = 2'd1;
    localparam state_t StDone = 2'd2;

    // Wide enough to hold any limit and any sign-extended product of interest.
    localparam int unsigned SatW = 128;

    function automatic logic signed [SatW-1:0] sat_hi(input int unsigned w,
                                                      input logic is_signed);
        logic signed [SatW-1:0] one;
        one = SatW'(1);
        return is_signed ? (one << (w - 1)) - one : (one << w) - one;
    endfunction

    function automatic logic signed [SatW-1:0] sat_lo(input int unsigned w,
                                                      input logic is_signed);
        logic signed [SatW-1:0] one;
        one = SatW'(1);
        return is_signed ? -(one << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/mul_fix_sat.sv
// Combinational fixed-point rescale: shifts a 2*D_W product right by FRAC (floor)
// and saturates it to D_W bits in the signed or unsigned range.
module mul_fix_sat
    import mul_pkg::*;
#(
    parameter int unsigned D_W  = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic [2*D_W-1:0] prod,
    input  logic             is_signed,
    output logic [D_W-1:0]   fix
);

    logic signed [2*D_W-1:0] prod_s;
    logic        [2*D_W-1:0] shifted;
    logic signed [SatW-1:0]  ext;
    logic signed [SatW-1:0]  hi;
    logic signed [SatW-1:0]  lo;

    always_comb begin
        prod_s = prod;
        if (is_signed) begin
            shifted = prod_s >>> FRAC;
        end else begin
            shifted = prod >> FRAC;
        end
        ext = {{(SatW - 2 * D_W){is_signed & shifted[2*D_W-1]}}, shifted};
        hi  = sat_hi(D_W, is_signed);
        lo  = sat_lo(D_W, is_signed);
        if (ext > hi) begin
            fix = is_signed ? {1'b0, {(D_W - 1){1'b1}}} : {D_W{1'b1}};
        end else if (ext < lo) begin
            fix = is_signed ? {1'b1, {(D_W - 1){1'b0}}} : {D_W{1'b0}};
        end else begin
            fix = shifted[D_W-1:0];
        end
    end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Radix-2 shift-add multiplier, one partial product per clock, with valid/ready on both sides.
// Works on magnitudes and applies the sign at the last step; also emits a saturated fixed-point result.
module seq_shift_add_mul
    import mul_pkg::*;
#(
    parameter int unsigned D_W  = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_VALID,
    output logic               O_READY,
    input  logic [D_W-1:0]     I_A,
    input  logic [D_W-1:0]     I_B,
    input  logic               I_SIGNED,
    output logic               O_VALID,
    input  logic               I_READY,
    output logic [2*D_W-1:0]   O_PROD,
    output logic [D_W-1:0]     O_FIX
);

    localparam int unsigned CntW = $clog2(D_W);

    state_t             state_q, state_d;
    logic [2*D_W-1:0]   mcand_q, mcand_d;
    logic [D_W-1:0]     mplier_q, mplier_d;
    logic [2*D_W-1:0]   acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               mode_q, mode_d;
    logic [2*D_W-1:0]   prod_q, prod_d;
    logic [D_W-1:0]     fix_q, fix_d;

    logic [D_W-1:0]     abs_a, abs_b;
    logic [2*D_W-1:0]   acc_step;
    logic [2*D_W-1:0]   prod_final;
    logic [D_W-1:0]     fix_final;

    // Most-negative input negates to itself, which is the correct unsigned magnitude.
    assign abs_a = (I_SIGNED && I_A[D_W-1]) ? (~I_A + D_W'(1)) : I_A;
    assign abs_b = (I_SIGNED && I_B[D_W-1]) ? (~I_B + D_W'(1)) : I_B;

    assign acc_step   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign prod_final = neg_q ? -acc_step : acc_step;

    mul_fix_sat #(
        .D_W  (D_W),
        .FRAC (FRAC)
    ) u_fix_sat (
        .prod      (prod_final),
        .is_signed (mode_q),
        .fix       (fix_final)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        mode_d   = mode_q;
        prod_d   = prod_q;
        fix_d    = fix_q;
        case (state_q)
            StIdle: begin
                if (I_VALID) begin
                    mcand_d  = {{D_W{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    neg_d    = I_SIGNED & (I_A[D_W-1] ^ I_B[D_W-1]);
                    mode_d   = I_SIGNED;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(D_W - 1)) begin
                    prod_d  = prod_final;
                    fix_d   = fix_final;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (I_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            mode_q   <= 1'b0;
            prod_q   <= '0;
            fix_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            mode_q   <= mode_d;
            prod_q   <= prod_d;
            fix_q    <= fix_d;
        end
    end

    assign O_READY = (state_q == StIdle);
    assign O_VALID = (state_q == StDone);
    assign O_PROD  = prod_q;
    assign O_FIX   = fix_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul (D_W=16, FRAC=8): directed vectors,
// randomized operands against an arithmetic model, backpressure and mid-operation reset.
module tb_seq_shift_add_mul;

    localparam int DW = 16;
    localparam int FR = 8;

    logic            I_CLK;
    logic            I_RST_N;
    logic            I_VALID;
    logic            O_READY;
    logic [DW-1:0]   I_A;
    logic [DW-1:0]   I_B;
    logic            I_SIGNED;
    logic            O_VALID;
    logic            I_READY;
    logic [2*DW-1:0] O_PROD;
    logic [DW-1:0]   O_FIX;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shift_add_mul #(
        .D_W  (DW),
        .FRAC (FR)
    ) dut (
        .I_CLK    (I_CLK),
        .I_RST_N  (I_RST_N),
        .I_VALID  (I_VALID),
        .O_READY  (O_READY),
        .I_A      (I_A),
        .I_B      (I_B),
        .I_SIGNED (I_SIGNED),
        .O_VALID  (O_VALID),
        .I_READY  (I_READY),
        .O_PROD   (O_PROD),
        .O_FIX    (O_FIX)
    );

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    // Reference: integer product, floor division by 2^FR, clamp to the output range.
    task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                         output logic [2*DW-1:0] p, output logic [DW-1:0] f);
        longint x, y, pp, sh;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        pp = x * y;
        p  = pp[2*DW-1:0];
        sh = pp >>> FR;
        if (s) begin
            if (sh > 32767) sh = 32767;
            if (sh < -32768) sh = -32768;
        end else begin
            if (sh > 65535) sh = 65535;
        end
        f = sh[DW-1:0];
    endtask

    // Issue one transaction from IDLE, wait (bounded) for the result, then handshake it.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                          output logic [2*DW-1:0] p, output logic [DW-1:0] f,
                          output int lat, output bit rdy_ok);
        I_A = a;
        I_B = b;
        I_SIGNED = s;
        I_VALID = 1'b1;
        @(posedge I_CLK);
        #1;
        I_VALID = 1'b0;
        I_A = DW'($urandom);
        I_B = DW'($urandom);
        I_SIGNED = 1'($urandom);
        rdy_ok = 1'b1;
        lat = 0;
        while (!O_VALID && lat < 100) begin
            if (O_READY) rdy_ok = 1'b0;
            @(posedge I_CLK);
            #1;
            lat++;
        end
        p = O_PROD;
        f = O_FIX;
        I_READY = 1'b1;
        @(posedge I_CLK);
        #1;
        I_READY = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (O_READY !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", O_READY);
        end
        n_checks++;
        if (O_VALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", O_VALID);
        end
        n_checks++;
        if (O_PROD !== '0) begin
            n_fail++; $display("FAIL reset_prod: got %h want 0", O_PROD);
        end
        n_checks++;
        if (O_FIX !== '0) begin
            n_fail++; $display("FAIL reset_fix: got %h want 0", O_FIX);
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0]   a_t [5] = '{16'h0003, 16'hFFFD, 16'h8000, 16'hFFFF, 16'h0180};
        logic [DW-1:0]   b_t [5] = '{16'h0005, 16'h0005, 16'h8000, 16'hFFFF, 16'hFE00};
        logic            s_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2*DW-1:0] p_t [5] = '{32'h0000000F, 32'hFFFFFFF1, 32'h40000000, 32'hFFFE0001,
                                     32'hFFFD0000};
        logic [DW-1:0]   f_t [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'hFD00};
        logic [2*DW-1:0] p;
        logic [DW-1:0]   f;
        int              lat;
        bit              rdy_ok;
        for (int i = 0; i < 5; i++) begin
            run_op(a_t[i], b_t[i], s_t[i], p, f, lat, rdy_ok);
            n_checks++;
            if (p !== p_t[i]) begin
                n_fail++; $display("FAIL directed_prod[%0d]: got %h want %h", i, p, p_t[i]);
            end
            n_checks++;
            if (f !== f_t[i]) begin
                n_fail++; $display("FAIL directed_fix[%0d]: got %h want %h", i, f, f_t[i]);
            end
            n_checks++;
            if (lat !== 16) begin
                n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 16", i, lat);
            end
            n_checks++;
            if (rdy_ok !== 1'b1) begin
                n_fail++; $display("FAIL directed_ready_low[%0d]: got %b want 1", i, rdy_ok);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0]   a, b;
        logic            s;
        logic [2*DW-1:0] p, ep;
        logic [DW-1:0]   f, ef;
        int              lat;
        bit              rdy_ok;
        for (int i = 0; i < 40; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: a = '0;
                1: b = 16'h8000;
                2: b = 16'hFFFF;
                3: a = DW'($urandom_range(0, 15));
                default: ;
            endcase
            model(a, b, s, ep, ef);
            run_op(a, b, s, p, f, lat, rdy_ok);
            n_checks++;
            if (p !== ep) begin
                n_fail++;
                $display("FAIL random_prod a=%h b=%h s=%b: got %h want %h", a, b, s, p, ep);
            end
            n_checks++;
            if (f !== ef) begin
                n_fail++;
                $display("FAIL random_fix a=%h b=%h s=%b: got %h want %h", a, b, s, f, ef);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2*DW-1:0] ep, ep2;
        logic [DW-1:0]   ef, ef2;
        int              lat;
        model(16'h0123, 16'h0456, 1'b0, ep, ef);
        model(16'hFFF7, 16'h000B, 1'b1, ep2, ef2);
        I_A = 16'h0123; I_B = 16'h0456; I_SIGNED = 1'b0; I_VALID = 1'b1;
        @(posedge I_CLK);
        #1;
        // Offer the next operands early; they must wait until after the handshake.
        I_A = 16'hFFF7; I_B = 16'h000B; I_SIGNED = 1'b1;
        lat = 0;
        while (!O_VALID && lat < 100) begin
            @(posedge I_CLK); #1; lat++;
        end
        n_checks++;
        if (lat !== 16) begin
            n_fail++; $display("FAIL bp_latency: got %0d want 16", lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (O_VALID !== 1'b1 || O_READY !== 1'b0 || O_PROD !== ep || O_FIX !== ef) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b p=%h f=%h want v=1 r=0 p=%h f=%h",
                         i, O_VALID, O_READY, O_PROD, O_FIX, ep, ef);
            end
            @(posedge I_CLK); #1;
        end
        I_READY = 1'b1;
        @(posedge I_CLK); #1;
        I_READY = 1'b0;
        n_checks++;
        if (O_VALID !== 1'b0 || O_READY !== 1'b1 || O_PROD !== ep) begin
            n_fail++;
            $display("FAIL bp_after_handshake: got v=%b r=%b p=%h want v=0 r=1 p=%h",
                     O_VALID, O_READY, O_PROD, ep);
        end
        @(posedge I_CLK); #1;
        I_VALID = 1'b0;
        n_checks++;
        if (O_READY !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept_next: got ready=%b want 0", O_READY);
        end
        lat = 0;
        while (!O_VALID && lat < 100) begin
            @(posedge I_CLK); #1; lat++;
        end
        n_checks++;
        if (lat !== 16 || O_PROD !== ep2 || O_FIX !== ef2) begin
            n_fail++;
            $display("FAIL bp_second_result: got lat=%0d p=%h f=%h want lat=16 p=%h f=%h",
                     lat, O_PROD, O_FIX, ep2, ef2);
        end
        // Leave the result pending so the reset test starts from non-zero outputs.
    endtask

    task automatic test_reset_mid_calc();
        logic [2*DW-1:0] p;
        logic [DW-1:0]   f;
        int              lat;
        bit              rdy_ok;
        bit              saw_valid;
        I_READY = 1'b1;
        @(posedge I_CLK); #1;
        I_READY = 1'b0;
        I_A = 16'h1234; I_B = 16'h5678; I_SIGNED = 1'b0; I_VALID = 1'b1;
        @(posedge I_CLK); #1;
        I_VALID = 1'b0;
        repeat (8) begin
            @(posedge I_CLK);
        end
        #2;
        I_RST_N = 1'b0;
        #1;
        n_checks++;
        if (O_VALID !== 1'b0 || O_READY !== 1'b1 || O_PROD !== '0 || O_FIX !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b r=%b p=%h f=%h want v=0 r=1 p=0 f=0",
                     O_VALID, O_READY, O_PROD, O_FIX);
        end
        repeat (2) @(posedge I_CLK);
        #1;
        I_RST_N = 1'b1;
        saw_valid = 1'b0;
        repeat (25) begin
            @(posedge I_CLK); #1;
            if (O_VALID) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_no_result: got valid seen=%b want 0", saw_valid);
        end
        run_op(16'd7, 16'd6, 1'b0, p, f, lat, rdy_ok);
        n_checks++;
        if (p !== 32'd42 || f !== 16'd0) begin
            n_fail++; $display("FAIL midreset_after_op: got p=%h f=%h want p=2a f=0", p, f);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        I_RST_N  = 1'b0;
        I_VALID  = 1'b0;
        I_READY  = 1'b0;
        I_A      = '0;
        I_B      = '0;
        I_SIGNED = 1'b0;
        #1;
        test_reset();
        repeat (3) @(posedge I_CLK);
        #1;
        I_RST_N = 1'b1;
        @(posedge I_CLK); #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
